// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key code constants and entry-buffer FSM states.
// Used by the keypad scanner consumers.
package keypad_pkg;

  localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
  localparam logic [3:0] KEY_BACKSPACE = 4'hD;
  localparam logic [3:0] KEY_ENTER     = 4'hE;
  localparam logic [3:0] KEY_CLEAR     = 4'hF;

  typedef enum logic {
    ST_ENTRY = 1'b0,
    ST_HOLD  = 1'b1
  } entry_state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= KEY_DIGIT_MAX);
  endfunction

endpackage

// File: rtl/key_entry_buffer_bcd_to_bin.sv
// Combinational packed-BCD to binary converter.
// Walks digits from most to least significant, accumulating acc*10 + digit.
module bcd_to_bin #(
  parameter int DIGITS = 4,
  parameter int VAL_W  = 14
) (
  input  logic [4*DIGITS-1:0] bcd,
  output logic [VAL_W-1:0]    bin
);

  always_comb begin
    bin = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      bin = (bin << 3) + (bin << 1) + VAL_W'(bcd[4*i +: 4]);
    end
  end

endmodule

// File: rtl/key_entry_buffer.sv
// Collects keypad events into a BCD entry with clear/backspace/enter editing,
// then offers the finished entry on a valid/ready port.
module key_entry_buffer
  import keypad_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int VAL_W  = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_flag,
  input  logic [3:0]          key_value,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic [VAL_W-1:0]    out_bin,
  output logic [3:0]          out_count,
  output logic [4*DIGITS-1:0] disp_bcd,
  output logic [3:0]          disp_count,
  output logic                overflow,
  output logic                dropped
);

  localparam int         BCD_W     = 4 * DIGITS;
  localparam logic [3:0] MAX_COUNT = 4'(DIGITS);

  entry_state_e     state_q, state_d;
  logic             key_evt_q, key_evt_d;
  logic [BCD_W-1:0] entry_q, entry_d;
  logic [3:0]       count_q, count_d;
  logic [VAL_W-1:0] bin_q, bin_d;
  logic             out_valid_q, out_valid_d;
  logic [BCD_W-1:0] out_bcd_q, out_bcd_d;
  logic [VAL_W-1:0] out_bin_q, out_bin_d;
  logic [3:0]       out_count_q, out_count_d;
  logic             overflow_q, overflow_d;
  logic             dropped_q, dropped_d;

  logic [BCD_W-1:0] shifted_entry;
  logic [VAL_W-1:0] shifted_bin;
  logic [VAL_W-1:0] live_bin;

  assign shifted_entry = entry_q >> 4;

  // Backspace cannot undo a multiply-add cheaply, so the value is rebuilt from digits.
  bcd_to_bin #(.DIGITS(DIGITS), .VAL_W(VAL_W)) u_backspace_conv (
    .bcd (shifted_entry),
    .bin (shifted_bin)
  );

  bcd_to_bin #(.DIGITS(DIGITS), .VAL_W(VAL_W)) u_reference_conv (
    .bcd (entry_q),
    .bin (live_bin)
  );

  always_comb begin
    state_d     = state_q;
    key_evt_d   = key_flag;
    entry_d     = entry_q;
    count_d     = count_q;
    bin_d       = bin_q;
    out_valid_d = out_valid_q;
    out_bcd_d   = out_bcd_q;
    out_bin_d   = out_bin_q;
    out_count_d = out_count_q;
    overflow_d  = 1'b0;
    dropped_d   = 1'b0;

    unique case (state_q)
      ST_ENTRY: begin
        if (key_evt_q) begin
          if (is_digit(key_value)) begin
            if (count_q < MAX_COUNT) begin
              entry_d = (entry_q << 4) | BCD_W'(key_value);
              count_d = count_q + 4'd1;
              bin_d   = (bin_q << 3) + (bin_q << 1) + VAL_W'(key_value);
            end else begin
              overflow_d = 1'b1;
            end
          end else begin
            case (key_value)
              KEY_BACKSPACE: begin
                if (count_q != 4'd0) begin
                  entry_d = shifted_entry;
                  count_d = count_q - 4'd1;
                  bin_d   = shifted_bin;
                end
              end
              KEY_ENTER: begin
                out_bcd_d   = entry_q;
                out_bin_d   = bin_q;
                out_count_d = count_q;
                out_valid_d = 1'b1;
                entry_d     = '0;
                count_d     = 4'd0;
                bin_d       = '0;
                state_d     = ST_HOLD;
              end
              KEY_CLEAR: begin
                entry_d = '0;
                count_d = 4'd0;
                bin_d   = '0;
              end
              default: ;
            endcase
          end
        end
      end
      ST_HOLD: begin
        // Events arriving while an entry waits are lost, even on the accept cycle.
        if (key_evt_q) begin
          dropped_d = 1'b1;
        end
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_ENTRY;
        end
      end
      default: state_d = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_ENTRY;
      key_evt_q   <= 1'b0;
      entry_q     <= '0;
      count_q     <= 4'd0;
      bin_q       <= '0;
      out_valid_q <= 1'b0;
      out_bcd_q   <= '0;
      out_bin_q   <= '0;
      out_count_q <= 4'd0;
      overflow_q  <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_evt_q   <= key_evt_d;
      entry_q     <= entry_d;
      count_q     <= count_d;
      bin_q       <= bin_d;
      out_valid_q <= out_valid_d;
      out_bcd_q   <= out_bcd_d;
      out_bin_q   <= out_bin_d;
      out_count_q <= out_count_d;
      overflow_q  <= overflow_d;
      dropped_q   <= dropped_d;
    end
  end

  // The incremental multiply-add value must always agree with a full conversion.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (bin_q == live_bin);
    end
  end

  assign out_valid  = out_valid_q;
  assign out_bcd    = out_bcd_q;
  assign out_bin    = out_bin_q;
  assign out_count  = out_count_q;
  assign disp_bcd   = entry_q;
  assign disp_count = count_q;
  assign overflow   = overflow_q;
  assign dropped    = dropped_q;

endmodule

// File: tb/tb_key_entry_buffer.sv
// Self-checking bench for key_entry_buffer: directed test-plan steps followed by
// random key traffic, compared every cycle against a digit-queue model.
module tb_key_entry_buffer;

  localparam int DIGITS = 4;
  localparam int VAL_W  = 14;
  localparam int BCD_W  = 4 * DIGITS;

  logic             clk;
  logic             rst_n;
  logic             key_flag;
  logic [3:0]       key_value;
  logic             out_ready;
  logic             out_valid;
  logic [BCD_W-1:0] out_bcd;
  logic [VAL_W-1:0] out_bin;
  logic [3:0]       out_count;
  logic [BCD_W-1:0] disp_bcd;
  logic [3:0]       disp_count;
  logic             overflow;
  logic             dropped;

  int errors = 0;
  int checks = 0;

  // Reference model state: digits in entry order, most significant first.
  int             m_digits[$];
  bit             m_holding;
  bit             m_evt;
  logic [BCD_W-1:0] m_out_bcd;
  int             m_out_bin;
  int             m_out_count;
  bit             m_ovf;
  bit             m_drop;

  key_entry_buffer #(.DIGITS(DIGITS), .VAL_W(VAL_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_flag   (key_flag),
    .key_value  (key_value),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_bcd    (out_bcd),
    .out_bin    (out_bin),
    .out_count  (out_count),
    .disp_bcd   (disp_bcd),
    .disp_count (disp_count),
    .overflow   (overflow),
    .dropped    (dropped)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  function automatic logic [BCD_W-1:0] model_bcd();
    logic [BCD_W-1:0] r = '0;
    int n = m_digits.size();
    for (int i = 0; i < n; i++) begin
      r = r | (BCD_W'(m_digits[n-1-i]) << (4 * i));
    end
    return r;
  endfunction

  function automatic int model_value();
    int v = 0;
    foreach (m_digits[i]) v = v * 10 + m_digits[i];
    return v;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_update();
    bit was_holding;
    int code;
    if (!rst_n) begin
      m_digits.delete();
      m_holding   = 0;
      m_evt       = 0;
      m_out_bcd   = '0;
      m_out_bin   = 0;
      m_out_count = 0;
      m_ovf       = 0;
      m_drop      = 0;
    end else begin
      m_ovf       = 0;
      m_drop      = 0;
      was_holding = m_holding;
      if (m_evt) begin
        code = int'(key_value);
        if (was_holding) begin
          m_drop = 1;
        end else if (code <= 9) begin
          if (m_digits.size() < DIGITS) m_digits.push_back(code);
          else m_ovf = 1;
        end else if (code == 13) begin
          if (m_digits.size() > 0) void'(m_digits.pop_back());
        end else if (code == 14) begin
          m_out_bcd   = model_bcd();
          m_out_bin   = model_value();
          m_out_count = m_digits.size();
          m_digits.delete();
          m_holding   = 1;
        end else if (code == 15) begin
          m_digits.delete();
        end
      end
      if (was_holding && out_ready) m_holding = 0;
      m_evt = key_flag;
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic checkOutput();
    checkValue("disp_bcd",   32'(disp_bcd),   32'(model_bcd()));
    checkValue("disp_count", 32'(disp_count), 32'(m_digits.size()));
    checkValue("out_valid",  32'(out_valid),  32'(m_holding));
    checkValue("out_bcd",    32'(out_bcd),    32'(m_out_bcd));
    checkValue("out_bin",    32'(out_bin),    32'(m_out_bin));
    checkValue("out_count",  32'(out_count),  32'(m_out_count));
    checkValue("overflow",   32'(overflow),   32'(m_ovf));
    checkValue("dropped",    32'(dropped),    32'(m_drop));
  endtask

  // Called at a falling edge: apply inputs, run one clock, check at the next falling edge.
  task automatic applyStimulus(input logic flag, input logic [3:0] value,
                               input logic ready, input logic rstn);
    key_flag  = flag;
    key_value = value;
    out_ready = ready;
    rst_n     = rstn;
    model_update();
    @(negedge clk);
    checkOutput();
  endtask

  // Key value is junk during the flag cycle and valid from the next cycle on.
  task automatic press(input logic [3:0] code, input logic ready);
    applyStimulus(1'b1, 4'($urandom), ready, 1'b1);
    applyStimulus(1'b0, code, ready, 1'b1);
    applyStimulus(1'b0, code, ready, 1'b1);
    applyStimulus(1'b0, code, ready, 1'b1);
  endtask

  initial begin
    rst_n     = 1'b0;
    key_flag  = 1'b0;
    key_value = 4'h0;
    out_ready = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b1);

    // 1,2,3,4 enter with ready held high
    press(4'h1, 1'b1); press(4'h2, 1'b1); press(4'h3, 1'b1); press(4'h4, 1'b1);
    press(4'hE, 1'b1);
    checkValue("plan1_bcd", 32'(out_bcd), 32'h1234);
    checkValue("plan1_bin", 32'(out_bin), 32'd1234);
    checkValue("plan1_count", 32'(out_count), 32'd4);

    // overflow on the fifth digit
    press(4'h9, 1'b1); press(4'h8, 1'b1); press(4'h7, 1'b1); press(4'h6, 1'b1);
    press(4'h5, 1'b1);
    press(4'hE, 1'b1);
    checkValue("plan2_bin", 32'(out_bin), 32'd9876);

    // backspace, including on an empty buffer
    press(4'hD, 1'b1);
    press(4'h4, 1'b1); press(4'h5, 1'b1); press(4'hD, 1'b1); press(4'h7, 1'b1);
    press(4'hE, 1'b1);
    checkValue("plan3_bcd", 32'(out_bcd), 32'h0047);
    checkValue("plan3_bin", 32'(out_bin), 32'd47);

    // clear, empty enter, ignored code
    press(4'h3, 1'b1); press(4'hF, 1'b1); press(4'hB, 1'b1);
    press(4'hE, 1'b1);
    checkValue("plan4_count", 32'(out_count), 32'd0);

    // held entry: key dropped, then accepted
    press(4'h2, 1'b0); press(4'hE, 1'b0);
    press(4'h6, 1'b0);
    applyStimulus(1'b0, 4'h6, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'h6, 1'b1, 1'b1);
    checkValue("plan5_disp", 32'(disp_count), 32'd0);

    // key event on the very cycle the held entry is accepted
    press(4'h8, 1'b0); press(4'hE, 1'b0);
    applyStimulus(1'b1, 4'h1, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'h5, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'h5, 1'b1, 1'b1);

    // reset mid-entry, with a key_flag during reset
    press(4'h1, 1'b1); press(4'h2, 1'b1);
    applyStimulus(1'b1, 4'h3, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h3, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'h3, 1'b1, 1'b1);
    press(4'h7, 1'b1);

    // random traffic
    for (int n = 0; n < 150; n++) begin
      logic [3:0] code;
      if ($urandom_range(0, 99) < 60) code = 4'($urandom_range(0, 9));
      else code = 4'($urandom_range(10, 15));
      press(code, 1'($urandom_range(0, 2) != 0));
      if ($urandom_range(0, 49) == 0) applyStimulus(1'b0, key_value, 1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_entry_buffer.md
# key_entry_buffer

Consumer of the keypad scanner's key_flag/key_value event interface. Collects debounced key events into a multi-digit BCD entry with clear, backspace and enter editing keys. On enter, presents the completed entry (packed BCD plus running binary value) on a valid/ready output port. Sits between the keypad scanner and the application FSM, which sees only complete numeric entries.

## Interface
- DIGITS, 4: maximum digits per entry (1..8)
- VAL_W, 14: binary value width; must hold 10^DIGITS − 1
- clk  in  1  system clock, 50 MHz, same domain as scanner
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- key_flag  in  1  one-cycle pulse per released key
- key_value  in  4  key code; valid from the cycle after key_flag, stable until next event
- out_ready  in  1  consumer accepts entry
- out_valid  out  1  completed entry available
- out_bcd  out  4*DIGITS  packed BCD, digit 0 (least significant) in [3:0], unused digits 0
- out_bin  out  VAL_W  binary value of entry
- out_count  out  4  number of digits entered (0..DIGITS)
- disp_bcd  out  4*DIGITS  live buffer contents for display
- disp_count  out  4  live digit count
- overflow  out  1  one-cycle pulse: digit key pressed with buffer full
- dropped  out  1  one-cycle pulse: key event lost while out_valid high

## Operation
- Key codes: 0x0–0x9 digit; 0xD backspace; 0xE enter; 0xF clear; 0xA–0xC ignored (no state change, no pulse).
- Event capture: key_flag registered to key_evt (1-cycle delay); key_value sampled when key_evt=1. Never sample key_value in the key_flag cycle.
- States: ENTRY, HOLD.
- ENTRY, digit, count<DIGITS: buffer shifts left one nibble, new digit in [3:0]; count+1; bin <= bin*10 + digit (computed as (bin<<3)+(bin<<1)+digit, truncated to VAL_W).
- ENTRY, digit, count==DIGITS: buffer unchanged; overflow pulses.
- ENTRY, backspace: count>0 → buffer shifts right one nibble (top nibble 0), count−1, bin recomputed from shifted buffer (must equal bin/10 of previous); count==0 → no change.
- ENTRY, clear: buffer, count, bin to 0.
- ENTRY, enter: copy buffer/bin/count to out_* registers, out_valid=1, clear live buffer, go HOLD. Enter with count==0 is legal: out_count=0, out_bin=0.
- HOLD: out_* frozen. out_valid && out_ready → out_valid=0, go ENTRY. Any key event in HOLD is discarded and pulses dropped, except when out_ready is high in that cycle, in which case it is still dropped (accept has priority, event not replayed).
- disp_* always reflect the live buffer (zero during HOLD).

## Timing
- Reset values: out_valid 0, out_bcd 0, out_bin 0, out_count 0, disp_bcd 0, disp_count 0, overflow 0, dropped 0; state ENTRY; key_evt 0.
- Latency: key_flag at cycle t → buffer/disp update visible at t+2; enter at t → out_valid high at t+2.
- out_valid deasserts the cycle after a cycle with out_valid && out_ready.
- overflow/dropped: high exactly one cycle, at t+2.
- key_flag asserted while rst_n low: ignored; no event captured across reset.
- Reset mid-entry or mid-HOLD: all state cleared, pending entry lost.
- Back-to-back key_flag on consecutive cycles is not produced by the scanner; behaviour is unspecified beyond no lock-up.

## Structure
- Shared package keypad_pkg: key code constants (KEY_BACKSPACE=4'hD, KEY_ENTER=4'hE, KEY_CLEAR=4'hF, digit range), state encoding for ENTRY/HOLD.
- One natural sub-module: bcd_to_bin, combinational, converts DIGITS packed BCD to VAL_W binary. It is used for the backspace recompute and as the reference check for the incremental multiply-add path.

## Test plan
- Keys 1,2,3,4, enter, out_ready held 1 → out_valid one cycle, out_bcd=16'h1234, out_bin=1234, out_count=4.
- Keys 9,8,7,6,5 (DIGITS=4) → overflow pulses on 5; enter → out_bcd=16'h9876, out_bin=9876.
- Keys 4,5, backspace, 7, enter → out_bcd=16'h0047, out_bin=47, out_count=2. Backspace on empty buffer → no change.
- Keys 3, clear, enter → out_count=0, out_bin=0. Key 0xB → no change, no pulse.
- Enter with out_ready=0, then key 6 → dropped pulses, out_* unchanged. Raise out_ready → out_valid falls next cycle, disp_count=0.
- Keys 1,2, then rst_n low one cycle mid-entry → disp_count=0, disp_bcd=0, out_valid=0. Next entry starts clean.
